// File: rtl/dma_mem_port.sv
// Memory-side transfer engine between the DMA nibble handshake port and a
// nibble-wide synchronous RAM: address generation, RAM strobes, busy/done.
module dma_mem_port #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [3:0]        mem_wdata,
  input  logic [3:0]        mem_rdata,
  input  logic              dma_to_mem_valid,
  output logic              dma_to_mem_enable,
  input  logic [3:0]        mem_data_in,
  output logic              mem_to_dma_valid,
  input  logic              mem_to_dma_enable,
  output logic [3:0]        mem_data_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_CAP, S_RD_OFFER, S_WR_ACCEPT, S_WR_COMMIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        hold_q, hold_d;
  logic [3:0]        wdata_q, wdata_d;
  logic              busy_q, done_q, rd_q, wr_q, valid_q, enable_q;

  // Handshake: a nibble moves only on a rising edge where valid and enable are
  // both high; the offering side holds valid and data stable until then.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = length;
          if (length == '0)  state_d = S_DONE;
          else if (dir)      state_d = S_WR_ACCEPT;
          else               state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP: begin
        hold_d  = mem_rdata;
        state_d = S_RD_OFFER;
      end
      S_RD_OFFER: begin
        if (mem_to_dma_enable) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_RD_ISSUE;
        end
      end
      S_WR_ACCEPT: begin
        if (dma_to_mem_valid) begin
          wdata_d = mem_data_in;
          state_d = S_WR_COMMIT;
        end
      end
      S_WR_COMMIT: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_WR_ACCEPT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats any same-cycle handshake; counters freeze for inspection.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      wdata_d = wdata_q;
    end
  end

  // Output flags are registered from the next state, so they equal a decode
  // of the state register with no combinational path from any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      hold_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      hold_q   <= hold_d;
      wdata_q  <= wdata_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      rd_q     <= (state_d == S_RD_ISSUE);
      wr_q     <= (state_d == S_WR_COMMIT);
      valid_q  <= (state_d == S_RD_OFFER);
      enable_q <= (state_d == S_WR_ACCEPT);
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign remaining         = rem_q;
  assign mem_addr          = addr_q;
  assign mem_rd            = rd_q;
  assign mem_wr            = wr_q;
  assign mem_wdata         = wdata_q;
  assign mem_to_dma_valid  = valid_q;
  assign dma_to_mem_enable = enable_q;
  assign mem_data_out      = hold_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_dma_mem_port.sv
// Bench for dma_mem_port: RAM model, directed and random transfers, and a
// queue-based scoreboard checking RAM strobes and DMA-side read data.
module tb_dma_mem_port;

  logic       clk, reset, start, dir, abort;
  logic [7:0] base_addr, length;
  logic       busy, done;
  logic [7:0] remaining, mem_addr;
  logic       mem_rd, mem_wr;
  logic [3:0] mem_wdata, mem_rdata, mem_data_in, mem_data_out;
  logic       dma_to_mem_valid, dma_to_mem_enable;
  logic       mem_to_dma_valid, mem_to_dma_enable;
  logic [2:0] dbg_state;

  dma_mem_port #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .base_addr(base_addr), .length(length), .abort(abort),
    .busy(busy), .done(done), .remaining(remaining),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_to_mem_valid(dma_to_mem_valid), .dma_to_mem_enable(dma_to_mem_enable),
    .mem_data_in(mem_data_in), .mem_to_dma_valid(mem_to_dma_valid),
    .mem_to_dma_enable(mem_to_dma_enable), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]  ram     [256];
  logic [3:0]  ref_mem [256];
  logic [3:0]  src     [256];
  logic [7:0]  exp_raddr_q[$];
  logic [3:0]  exp_rdata_q[$];
  logic [11:0] exp_wr_q[$];

  int rd_seen = 0, wr_seen = 0, wr_hs = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got strobe expected none", name);
  endtask

  // RAM model: read data appears one cycle after the read strobe
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] = mem_wdata;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd) begin
        rd_seen++;
        if (exp_raddr_q.size() == 0) unexpected("rd_strobe");
        else check("rd_addr", 32'(mem_addr), 32'(exp_raddr_q.pop_front()));
      end
      if (mem_wr) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) unexpected("wr_strobe");
        else check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q.pop_front()));
      end
      if (mem_to_dma_valid && mem_to_dma_enable) begin
        if (exp_rdata_q.size() == 0) unexpected("dma_rd_hs");
        else check("dma_rdata", 32'(mem_data_out), 32'(exp_rdata_q.pop_front()));
      end
      if (dma_to_mem_valid && dma_to_mem_enable) wr_hs++;
      if (done) done_cnt++;
    end
  end

  // reference model: expected strobes/data from base, length and RAM image
  task automatic push_expect(input logic d, input logic [7:0] base, input int len);
    logic [7:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 8'(i);
      if (d) begin
        exp_wr_q.push_back({a, src[i]});
        ref_mem[a] = src[i];
      end else begin
        exp_raddr_q.push_back(a);
        exp_rdata_q.push_back(ref_mem[a]);
      end
    end
  endtask

  task automatic issue(input logic d, input logic [7:0] base, input logic [7:0] len);
    start = 1'b1; dir = d; base_addr = base; length = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_cycle(input logic d, input int stall, input int hs0, input int len);
    int idx;
    if (d) begin
      dma_to_mem_valid  = ($urandom_range(0, 99) >= stall);
      mem_to_dma_enable = 1'b0;
      idx = wr_hs - hs0;
      mem_data_in = (idx < len) ? src[idx] : 4'h0;
    end else begin
      mem_to_dma_enable = ($urandom_range(0, 99) >= stall);
      dma_to_mem_valid  = 1'b0;
    end
  endtask

  task automatic finish_xfer(input logic d, input int len, input int stall, input int hs0);
    int  d0 = done_cnt;
    bit  ok = 0;
    for (int c = 0; c < 2000; c++) begin
      drive_cycle(d, stall, hs0, len);
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    if (!ok) unexpected("done_timeout");
    mem_to_dma_enable = 1'b0;
    dma_to_mem_valid  = 1'b0;
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
    check("remaining_end", 32'(remaining), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_count", done_cnt, d0 + 1);
    check("queues_drained", exp_raddr_q.size() + exp_rdata_q.size() + exp_wr_q.size(), 0);
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_to_dma_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) unexpected("valid_timeout");
  endtask

  initial begin
    logic [3:0] d_hold;
    int         r0, ws0, hs0, d0, len;
    logic       rdir;
    logic [7:0] rbase;

    reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    dma_to_mem_valid = 1'b0; mem_to_dma_enable = 1'b0; mem_data_in = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 4'($urandom_range(0, 15));
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 4'hA; ram[8'h11] = 4'hB; ram[8'h12] = 4'hC; ram[8'h13] = 4'hD;
    for (int i = 8'h10; i <= 8'h13; i++) ref_mem[i] = ram[i];
    #1;
    check("reset_outputs", 32'({busy, done, mem_rd, mem_wr, mem_to_dma_valid,
          dma_to_mem_enable, mem_addr, mem_wdata, mem_data_out, remaining}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // read 4 from 0x10, checking first-transfer latency
    push_expect(1'b0, 8'h10, 4);
    mem_to_dma_enable = 1'b1;
    issue(1'b0, 8'h10, 8'd4);
    check("rd_c1_mem_rd", 32'(mem_rd), 1);
    check("rd_c1_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("rd_c2_valid", 32'(mem_to_dma_valid), 0);
    @(posedge clk); #1;
    check("rd_c3_valid", 32'(mem_to_dma_valid), 1);
    finish_xfer(1'b0, 4, 0, 0);

    // write 5,6,7 at 0xFE with address wrap
    src[0] = 4'h5; src[1] = 4'h6; src[2] = 4'h7;
    push_expect(1'b1, 8'hFE, 3);
    hs0 = wr_hs;
    dma_to_mem_valid = 1'b1; mem_data_in = src[0];
    issue(1'b1, 8'hFE, 8'd3);
    check("wr_c1_enable", 32'(dma_to_mem_enable), 1);
    finish_xfer(1'b1, 3, 0, hs0);

    // read 2 with a 5-cycle stall in the offer state; a start here is ignored
    push_expect(1'b0, 8'h40, 2);
    mem_to_dma_enable = 1'b0;
    issue(1'b0, 8'h40, 8'd2);
    wait_valid();
    d_hold = mem_data_out;
    r0 = rd_seen;
    start = 1'b1; dir = 1'b1; base_addr = 8'h00; length = 8'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("stall_valid", 32'(mem_to_dma_valid), 1);
      check("stall_data", 32'(mem_data_out), 32'(d_hold));
    end
    check("stall_no_extra_rd", rd_seen, r0);
    check("stall_remaining", 32'(remaining), 2);
    finish_xfer(1'b0, 2, 0, 0);

    // zero-length transfer
    issue(1'b0, 8'h33, 8'd0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("len0_busy_low", 32'(busy), 0);
    check("len0_done_low", 32'(done), 0);

    // write 8, abort after the third RAM write
    for (int i = 0; i < 8; i++) src[i] = 4'($urandom_range(0, 15));
    push_expect(1'b1, 8'h80, 3);
    hs0 = wr_hs; ws0 = wr_seen; d0 = done_cnt;
    dma_to_mem_valid = 1'b1; mem_data_in = src[0];
    issue(1'b1, 8'h80, 8'd8);
    for (int c = 0; c < 100; c++) begin
      if (wr_seen - ws0 >= 3) break;
      mem_data_in = src[wr_hs - hs0];
      @(posedge clk); #1;
    end
    mem_data_in = src[wr_hs - hs0];
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; dma_to_mem_valid = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_remaining", 32'(remaining), 5);
    check("abort_no_wr", 32'(mem_wr), 0);
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    check("abort_no_done", done_cnt, d0);
    check("abort_wr_count", wr_seen - ws0, 3);

    // asynchronous reset while offering, then a fresh transfer
    push_expect(1'b0, 8'h20, 3);
    mem_to_dma_enable = 1'b0;
    issue(1'b0, 8'h20, 8'd3);
    wait_valid();
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({busy, done, mem_rd, mem_wr, mem_to_dma_valid,
          dma_to_mem_enable, mem_addr, mem_wdata, mem_data_out, remaining}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_raddr_q.delete(); exp_rdata_q.delete(); exp_wr_q.delete();
    @(posedge clk); #1;
    push_expect(1'b0, 8'h20, 3);
    issue(1'b0, 8'h20, 8'd3);
    finish_xfer(1'b0, 3, 30, 0);

    // random transfers
    for (int t = 0; t < 12; t++) begin
      rdir  = 1'($urandom_range(0, 1));
      rbase = 8'($urandom_range(0, 255));
      len   = $urandom_range(0, 10);
      for (int i = 0; i < len; i++) src[i] = 4'($urandom_range(0, 15));
      push_expect(rdir, rbase, len);
      hs0 = wr_hs;
      drive_cycle(rdir, 0, hs0, len);
      issue(rdir, rbase, 8'(len));
      finish_xfer(rdir, len, $urandom_range(0, 60), hs0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
